// File: rtl/cnt_race_pkg.sv
// Shared defaults for the counter-race block: channel count, counter width,
// tally width and the leader-index width derived from the default channel count.
package cnt_race_pkg;
   localparam int N_DEF  = 4;
   localparam int W_DEF  = 10;
   localparam int TW_DEF = 4;
   localparam int LEAD_W = $clog2(N_DEF);
endpackage

// File: rtl/cnt_mod.sv
// One W-bit modulo counter with a registered wrap pulse. Modulus 0 parks the
// counter at 0; modulus 1 parks it at 0 and wraps on every enabled cycle.
module cnt_mod
   import cnt_race_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] modulus,
   output logic [W-1:0] cnt,
   output logic         cout
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         cout_q, cout_d;

   // Using >= rather than == makes a shrunken modulus wrap on the next enabled edge.
   always_comb begin
      cnt_d  = cnt_q;
      cout_d = 1'b0;
      if (en) begin
         if (modulus == '0) begin
            cnt_d = '0;
         end else if (cnt_q >= modulus - W'(1)) begin
            cnt_d  = '0;
            cout_d = 1'b1;
         end else begin
            cnt_d = cnt_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         cout_q <= cout_d;
      end
   end

   assign cnt  = cnt_q;
   assign cout = cout_q;

endmodule

// File: rtl/cnt_race_n.sv
// N racing modulo counters; wrap pulses feed saturating, normalised carry
// tallies with sticky saturation flags and a combinational leader/tie report.
module cnt_race_n
   import cnt_race_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int W  = W_DEF,
   parameter int TW = TW_DEF
) (
   input  logic                   CLK,
   input  logic                   rst_n,
   input  logic [N-1:0]           en,
   input  logic [N*W-1:0]         cnt_module,
   input  logic                   clr,
   output logic [N*W-1:0]         cnt,
   output logic [N-1:0]           cout,
   output logic                   cnt_all_eq,
   output logic [N*TW-1:0]        tally,
   output logic [N-1:0]           sat,
   output logic [$clog2(N)-1:0]   lead_idx,
   output logic                   tie,
   output logic                   all_eq
);

   localparam int LW = $clog2(N);
   localparam logic [TW-1:0] TMAX = '1;

   logic [TW-1:0] tally_q [N];
   logic [TW-1:0] tally_d [N];
   logic [TW-1:0] nxt     [N];
   logic [N-1:0]  sat_q, sat_d;
   logic          allNz;
   logic [TW-1:0] maxV;
   logic          seenMax;

   for (genvar g = 0; g < N; g++) begin : g_ch
      cnt_mod #(.W(W)) u_cnt (
         .clk     (CLK),
         .rst_n   (rst_n),
         .en      (en[g]),
         .modulus (cnt_module[g*W +: W]),
         .cnt     (cnt[g*W +: W]),
         .cout    (cout[g])
      );
      assign tally[g*TW +: TW] = tally_q[g];
   end

   // Saturating increment first; only when every channel is non-zero is the common floor removed.
   always_comb begin
      allNz = 1'b1;
      sat_d = sat_q;
      for (int i = 0; i < N; i++) begin
         if (cout[i] && (tally_q[i] == TMAX)) begin
            nxt[i]   = tally_q[i];
            sat_d[i] = 1'b1;
         end else begin
            nxt[i] = tally_q[i] + TW'(cout[i]);
         end
         if (nxt[i] == '0) allNz = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         tally_d[i] = allNz ? nxt[i] - TW'(1) : nxt[i];
         if (clr) tally_d[i] = '0;
      end
      if (clr) sat_d = '0;
   end

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) tally_q[i] <= '0;
         sat_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) tally_q[i] <= tally_d[i];
         sat_q <= sat_d;
      end
   end

   assign sat = sat_q;

   always_comb begin
      maxV     = tally_q[0];
      lead_idx = '0;
      for (int i = 1; i < N; i++) begin
         if (tally_q[i] > maxV) begin
            maxV     = tally_q[i];
            lead_idx = LW'(i);
         end
      end
      seenMax = 1'b0;
      tie     = 1'b0;
      all_eq  = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (tally_q[i] == maxV) begin
            if (seenMax) tie = 1'b1;
            seenMax = 1'b1;
         end
         if (tally_q[i] != tally_q[0]) all_eq = 1'b0;
      end
   end

   always_comb begin
      cnt_all_eq = 1'b1;
      for (int i = 1; i < N; i++) begin
         if (cnt[i*W +: W] != cnt[W-1:0]) cnt_all_eq = 1'b0;
      end
   end

endmodule

// File: doc/cnt_race_n.md
CNT_RACE_N -- requirements
Module: cnt_race_n

Interface
REQ-001 Parameter N, default 4, number of counter channels (range 2..8).
REQ-002 Parameter W, default 10, counter and modulus width in bits.
REQ-003 Parameter TW, default 4, carry-tally width in bits.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 en  input  N  per-channel count enable.
REQ-007 cnt_module  input  N x W  per-channel modulus.
REQ-008 clr  input  1  synchronous clear of tallies and sat flags only.
REQ-009 cnt  output  N x W  per-channel count value.
REQ-010 cout  output  N  per-channel registered wrap pulse.
REQ-011 cnt_all_eq  output  1  all cnt values equal (combinational).
REQ-012 tally  output  N x TW  normalised carry tally per channel.
REQ-013 sat  output  N  sticky tally-saturation flag per channel.
REQ-014 lead_idx  output  clog2(N)  channel with the highest tally.
REQ-015 tie  output  1  more than one channel holds the maximum tally.
REQ-016 all_eq  output  1  all tallies equal.

Function
REQ-017 Counter i with en[i]=1 and cnt_module[i]>=2 shall count 0..cnt_module[i]-1, then wrap to 0.
REQ-018 cout[i] shall be 1 for exactly the one cycle in which cnt[i] has just wrapped to 0, and 0 otherwise.
REQ-019 With en[i]=0, cnt[i] shall hold its value and cout[i] shall be 0.
REQ-020 cnt_module[i]=0 shall hold cnt[i] at 0 with no cout; cnt_module[i]=1 shall hold cnt[i] at 0 and pulse cout[i] on every enabled cycle.
REQ-021 If cnt_module[i] changes so that cnt[i] >= new modulus-1, the next enabled edge shall wrap cnt[i] to 0 and pulse cout[i].
REQ-022 Tally update, one cycle after cout: nxt[i] = tally[i] + cout[i], saturating at 2^TW-1.
REQ-023 Normalisation: if every nxt[i] is at least 1, then every channel shall store nxt[i]-1; otherwise it shall store nxt[i].
REQ-024 sat[i] shall set when a cout[i] increment is dropped at 2^TW-1, and shall stay set until reset or clr.
REQ-025 lead_idx shall be the lowest index holding the maximum tally; lead_idx, tie and all_eq shall be combinational from tally.
REQ-026 clr=1 shall zero tally and sat on the next edge, with counters unaffected; cout pulses in that same cycle are discarded.
REQ-027 Simultaneous couts on several channels shall all be counted in the same update.

Reset
REQ-028 rst_n=0 at an edge shall set cnt=0, cout=0, tally=0 and sat=0, giving lead_idx=0, tie=1, all_eq=1 and cnt_all_eq=1.
REQ-029 Reset shall take priority over clr and en, and shall abort any in-progress count mid-sequence.

Structure
REQ-030 Package cnt_race_pkg shall hold the default N, W and TW values and the LEAD_W = clog2(N) helper constant.
REQ-031 A sub-module cnt_mod (one W-bit modulo counter with registered cout) shall be instantiated N times.
REQ-032 The tally, normalisation and leader logic shall reside in the top module.

Verification (N=4, W=10, TW=4)
REQ-033 Reset: assert rst_n=0 for 2 cycles -> all cnt=0, cout=0, tally=0, lead_idx=0, tie=1, all_eq=1.
REQ-034 Set ch0 cnt_module=5 and en=1 -> cnt0 runs 1,2,3,4,0 and cout0=1 only in the 5th cycle; repeat 3 periods.
REQ-035 Set ch1 cnt_module=0 and ch2 cnt_module=1 -> cnt1=cnt2=0 throughout, cout1 never asserts, cout2=1 every cycle.
REQ-036 Set modules 3,4,6,12 with all en=1 for 12 cycles -> tallies 3,2,1,0 after normalisation, lead_idx=0, tie=0; modules 4,4,8,8 -> lead_idx=0, tie=1.
REQ-037 Set ch0 cnt_module=1 with other en=0 for 20 cycles -> tally0=15, sat0=1; then pulse clr -> tally0=0, sat0=0.
REQ-038 Drop rst_n mid-count with cnt0=3 -> next edge gives all outputs at reset values; the count restarts from 0 after release.
